// File: rtl/affine_exu_pkg.sv
// Shared definitions for the affine execute unit: datapath sizing,
// operation and FSM encodings, and the signed saturation limits.
package affine;

  localparam int N    = 16;
  localparam int FRAC = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_DMAC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MULT = 2'b01,
    S_NORM = 2'b10,
    S_ACC  = 2'b11
  } exu_state_e;

  // Largest and smallest representable N-bit two's complement values.
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/affine_smul.sv
// Iterative unsigned shift-add multiplier. Consumes one multiplier bit per
// cycle, LSB first, over N cycles. done_o is high during the cycle whose
// closing edge performs the final step, so prod_o is complete right after it.
module affine_smul #(
  parameter int N = affine::N
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);

  localparam int CW = $clog2(N) + 1;

  logic           run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           last;

  assign last   = run_q && (cnt_q == CW'(N - 1));
  assign done_o = last;
  assign prod_o = prod_q;

  // Next-state: load on start, otherwise one conditional add and shift per cycle.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{N{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
    end else if (run_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) run_d = 1'b0;
    end
  end

  // State registers; reset clears the counter and the partial product.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/affine_exu.sv
// Affine execute unit: single-cycle saturating ADD/SUB, iterative
// sign-magnitude fixed-point MUL with round-half-away-from-zero, and dual
// multiply-accumulate (DMAC) producing a result pair for the accumulators.
module affine_exu
  import affine::*;
#(
  parameter int N    = affine::N,
  parameter int FRAC = affine::FRAC
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] rs_data_i,
  input  logic [N-1:0] rd_data_i,
  input  logic [N-1:0] acc1_i,
  input  logic [N-1:0] acc2_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         wen_o,
  output logic         wdual_o,
  output logic [N-1:0] wd_data_o,
  output logic [N-1:0] acc2_o,
  output logic         ovf_o
);

  localparam logic [N-1:0]   MAX_V   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   MIN_V   = {1'b1, {(N-1){1'b0}}};
  // Magnitude limits for the rounded product: 2^(N-1)-1 positive, 2^(N-1) negative.
  localparam logic [2*N:0]   LIM_POS = {{(N+1){1'b0}}, 1'b0, {(N-1){1'b1}}};
  localparam logic [2*N:0]   LIM_NEG = {{(N+1){1'b0}}, 1'b1, {(N-1){1'b0}}};
  // Half an LSB of the result, added to the magnitude before truncation.
  localparam logic [2*N:0]   RND     = (FRAC == 0) ? '0 :
                                       ((2*N+1)'(1) << ((FRAC == 0) ? 0 : FRAC - 1));

  // Returns {overflow, saturated x+y} or {overflow, saturated x-y}.
  function automatic logic [N:0] sat_addsub(input logic [N-1:0] x,
                                            input logic [N-1:0] y,
                                            input logic         sub);
    logic [N:0] s;
    if (sub) s = {x[N-1], x} - {y[N-1], y};
    else     s = {x[N-1], x} + {y[N-1], y};
    if (s[N] != s[N-1]) return {1'b1, (s[N] ? MIN_V : MAX_V)};
    return {1'b0, s[N-1:0]};
  endfunction

  exu_state_e     state_q, state_d;
  op_e            op_q, op_d;
  logic           neg_q, neg_d;
  logic [N-1:0]   acc1_q, acc1_d;
  logic [N-1:0]   acc2in_q, acc2in_d;
  logic [N-1:0]   p_q, p_d;
  logic           povf_q, povf_d;
  logic [N-1:0]   wd_q, wd_d;
  logic [N-1:0]   acc2_q, acc2_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;
  logic           wen_q, wen_d;
  logic           wdual_q, wdual_d;

  logic [N-1:0]   a_mag, b_mag;
  logic           mul_start, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [2*N:0]   rnd_sum, rnd_mag;
  logic [N-1:0]   rnd_low;
  logic           p_sat;
  logic [N-1:0]   p_val;
  logic [N:0]     add_res, sub_res, acc1_res, acc2_res;

  assign a_mag     = rs_data_i[N-1] ? (~rs_data_i + N'(1)) : rs_data_i;
  assign b_mag     = rd_data_i[N-1] ? (~rd_data_i + N'(1)) : rd_data_i;
  assign mul_start = start_i && (state_q == S_IDLE) && op_i[1];

  affine_smul #(.N(N)) u_smul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(mul_start),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  // Round the unsigned magnitude, clamp against the sign-dependent limit, reapply sign.
  always_comb begin
    rnd_sum = {1'b0, mul_prod} + RND;
    rnd_mag = rnd_sum >> FRAC;
    rnd_low = rnd_mag[N-1:0];
    p_sat   = neg_q ? (rnd_mag > LIM_NEG) : (rnd_mag > LIM_POS);
    if (p_sat)      p_val = neg_q ? MIN_V : MAX_V;
    else if (neg_q) p_val = ~rnd_low + N'(1);
    else            p_val = rnd_low;
  end

  assign add_res  = sat_addsub(rs_data_i, rd_data_i, 1'b0);
  assign sub_res  = sat_addsub(rd_data_i, rs_data_i, 1'b1);
  assign acc1_res = sat_addsub(acc1_q, p_q, 1'b0);
  assign acc2_res = sat_addsub(acc2in_q, p_q, 1'b1);

  // FSM next state and registered result/strobe updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc1_d   = acc1_q;
    acc2in_d = acc2in_q;
    p_d      = p_q;
    povf_d   = povf_q;
    wd_d     = wd_q;
    acc2_d   = acc2_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    wdual_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d     = op_e'(op_i);
          neg_d    = rs_data_i[N-1] ^ rd_data_i[N-1];
          acc1_d   = acc1_i;
          acc2in_d = acc2_i;
          case (op_e'(op_i))
            OP_ADD: begin
              {ovf_d, wd_d} = add_res;
              done_d = 1'b1;
              wen_d  = 1'b1;
            end
            OP_SUB: begin
              {ovf_d, wd_d} = sub_res;
              done_d = 1'b1;
              wen_d  = 1'b1;
            end
            default: state_d = S_MULT;
          endcase
        end
      end
      S_MULT: begin
        if (mul_done) state_d = S_NORM;
      end
      S_NORM: begin
        if (op_q == OP_MUL) begin
          wd_d    = p_val;
          ovf_d   = p_sat;
          done_d  = 1'b1;
          wen_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          p_d     = p_val;
          povf_d  = p_sat;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        wd_d    = acc1_res[N-1:0];
        acc2_d  = acc2_res[N-1:0];
        ovf_d   = povf_q | acc1_res[N] | acc2_res[N];
        done_d  = 1'b1;
        wdual_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation and zeroes outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      neg_q    <= 1'b0;
      acc1_q   <= '0;
      acc2in_q <= '0;
      p_q      <= '0;
      povf_q   <= 1'b0;
      wd_q     <= '0;
      acc2_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      wdual_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc1_q   <= acc1_d;
      acc2in_q <= acc2in_d;
      p_q      <= p_d;
      povf_q   <= povf_d;
      wd_q     <= wd_d;
      acc2_q   <= acc2_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
      wdual_q  <= wdual_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign wen_o     = wen_q;
  assign wdual_o   = wdual_q;
  assign wd_data_o = wd_q;
  assign acc2_o    = acc2_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_affine_exu.sv
// Directed bench for affine_exu (N=16, FRAC=8).
module tb_affine_exu;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] MUL  = 2'b10;
  localparam logic [1:0] DMAC = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] rs, rd, acc1, acc2;
  logic        busy, done, wen, wdual, ovf;
  logic [15:0] wd, acc2_out;

  int compared = 0;
  int mism     = 0;

  affine_exu #(.N(16), .FRAC(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rs_data_i(rs),
    .rd_data_i(rd),
    .acc1_i   (acc1),
    .acc2_i   (acc2),
    .busy_o   (busy),
    .done_o   (done),
    .wen_o    (wen),
    .wdual_o  (wdual),
    .wd_data_o(wd),
    .acc2_o   (acc2_out),
    .ovf_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation from posedge+1, follow it to done_o, check everything.
  task automatic run(input string tag, input logic [1:0] o, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] c1, input logic [15:0] c2,
                     input int lat, input logic [15:0] ewd, input logic [15:0] eacc2,
                     input logic eovf, input logic poke);
    int e;
    int bcnt;
    op = o; rs = a; rd = b; acc1 = c1; acc2 = c2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: operands must have been latched on the accepting edge.
    op = ADD; rs = ~a; rd = ~b; acc1 = ~c1; acc2 = ~c2;
    e = 1; bcnt = 0;
    while (!done && e < 64) begin
      if (busy) bcnt++;
      start = poke && busy;
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    $display("%s: op=%0d a=%h b=%h acc1=%h acc2=%h -> wd=%h acc2_o=%h ovf=%b lat=%0d",
             tag, o, a, b, c1, c2, wd, acc2_out, ovf, e);
    chk({tag, "_latency"}, e, lat);
    chk({tag, "_busy_cycles"}, bcnt, lat - 1);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_wd"}, {16'd0, wd}, {16'd0, ewd});
    chk({tag, "_acc2"}, {16'd0, acc2_out}, {16'd0, eacc2});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({tag, "_wen"}, {31'd0, wen}, {31'd0, (o != DMAC)});
    chk({tag, "_wdual"}, {31'd0, wdual}, {31'd0, (o == DMAC)});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int e;
    int dcnt;
    rst_n = 1'b0; start = 1'b0; op = ADD;
    rs = '0; rd = '0; acc1 = '0; acc2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_wd", {16'd0, wd}, 0);
    chk("reset_ovf", {31'd0, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD/SUB: single edge, saturating at N+1 bits.
    run("add_ovf",  ADD, 16'h0200, 16'h7F00, 16'h0, 16'h0, 1, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run("add_norm", ADD, 16'h0180, 16'hFF00, 16'h0, 16'h0, 1, 16'h0080, 16'h0000, 1'b0, 1'b0);
    run("sub_norm", SUB, 16'h0300, 16'h0100, 16'h0, 16'h0, 1, 16'hFE00, 16'h0000, 1'b0, 1'b0);
    run("sub_ovf",  SUB, 16'h0100, 16'h8000, 16'h0, 16'h0, 1, 16'h8000, 16'h0000, 1'b1, 1'b0);

    // MUL: N+2 edges, rounding half away from zero, sign-dependent limits.
    run("mul_sign", MUL, 16'h0180, 16'hFE00, 16'h0, 16'h0, 18, 16'hFD00, 16'h0000, 1'b0, 1'b0);
    run("mul_rnd1", MUL, 16'h0001, 16'h0080, 16'h0, 16'h0, 18, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run("mul_rnd2", MUL, 16'hFFFF, 16'h0080, 16'h0, 16'h0, 18, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run("mul_rnd3", MUL, 16'h0001, 16'h007F, 16'h0, 16'h0, 18, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run("mul_neglim", MUL, 16'h8000, 16'h0100, 16'h0, 16'h0, 18, 16'h8000, 16'h0000, 1'b0, 1'b0);
    run("mul_poslim", MUL, 16'h8000, 16'hFF00, 16'h0, 16'h0, 18, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run("mul_big",  MUL, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 18, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

    // DMAC: p = 2.0*3.0 = 0x0600; wd = acc1+p, acc2_o = acc2-p.
    run("dmac",     DMAC, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 19, 16'h0700, 16'hFB00, 1'b0, 1'b0);
    run("dmac_sat", DMAC, 16'h0200, 16'h0300, 16'h7F00, 16'h0100, 19, 16'h7FFF, 16'hFB00, 1'b1, 1'b0);

    // Start pulses while busy are ignored; acc2_o holds across a MUL.
    run("mul_poke", MUL, 16'h0180, 16'hFE00, 16'h0, 16'h0, 18, 16'hFD00, 16'hFB00, 1'b0, 1'b1);

    // Reset at MULT cycle 5: outputs clear, no done_o ever appears.
    op = MUL; rs = 16'h0180; rd = 16'hFE00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wdual", {31'd0, wdual}, 0);
    chk("rst_wd", {16'd0, wd}, 0);
    chk("rst_acc2", {16'd0, acc2_out}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    $display("reset_mid_mult: done/busy cycles after reset=%0d", dcnt);
    chk("rst_no_done", dcnt, 0);
    run("add_after_rst", ADD, 16'h0100, 16'h0100, 16'h0, 16'h0, 1, 16'h0200, 16'h0000, 1'b0, 1'b0);

    // Back-to-back: MUL then ADD with start_i held through the done cycle.
    op = MUL; rs = 16'h0200; rd = 16'h0300; start = 1'b1;
    @(posedge clk); #1;
    op = ADD; rs = 16'h0100; rd = 16'h0200;
    e = 1;
    while (!done && e < 64) begin
      @(posedge clk); #1;
      e++;
    end
    $display("b2b_mul: wd=%h ovf=%b lat=%0d", wd, ovf, e);
    chk("b2b_mul_latency", e, 18);
    chk("b2b_mul_wd", {16'd0, wd}, 32'h0600);
    chk("b2b_mul_wen", {31'd0, wen}, 1);
    @(posedge clk); #1;
    start = 1'b0;
    $display("b2b_add: wd=%h ovf=%b done=%b", wd, ovf, done);
    chk("b2b_add_done", {31'd0, done}, 1);
    chk("b2b_add_wd", {16'd0, wd}, 32'h0300);
    chk("b2b_add_wen", {31'd0, wen}, 1);
    chk("b2b_add_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("b2b_done_pulse", {31'd0, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
